sd_fifo_rx_drainer: RTL and testbench

Receive-side counterpart of the SD DMA transmit filler. Accepts 32-bit words from the SD data-serial receive path into an internal FIFO. Drains each word to system memory as a single Wishbone master write at `adr + offset`, advancing the offset per word. Sits between the SD data-serial receiver and the Wishbone master port of the SD controller.

---
 rtl/sd_fifo_rx_drainer.sv | 169 ++++++++++++++++
 tb/tb_sd_fifo_rx_drainer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_fifo_rx_drainer.sv
// Receive-side drainer: buffers words from the SD serial receiver in a small FIFO
// and writes each one to memory as a single Wishbone write at adr + offset.
module sd_fifo_rx_drainer #(
    parameter int DEPTH_LOG2 = 3,
    parameter int MEM_OFFSET = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] adr,
    input  logic        wr,
    input  logic [31:0] dat_i,
    output logic        full,
    output logic        empty,
    output logic        overflow,
    output logic [8:0]  words_done,
    output logic [31:0] m_wb_adr_o,
    output logic [31:0] m_wb_dat_o,
    output logic [3:0]  m_wb_sel_o,
    output logic        m_wb_we_o,
    output logic        m_wb_cyc_o,
    output logic        m_wb_stb_o,
    input  logic        m_wb_ack_i
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [8:0] OFFSET_STEP = 9'(MEM_OFFSET);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_t;

    logic [31:0]           mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    state_t                state_r;
    state_t                state_next_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  done_s;
    logic                  full_s;
    logic                  empty_s;
    logic [8:0]            offset_r;
    logic [8:0]            words_done_r;
    logic [31:0]           dat_r;
    logic                  cyc_r;
    logic                  stb_r;
    logic                  we_r;
    logic [3:0]            sel_r;
    logic                  overflow_r;

    assign full_s  = (count_r == COUNT_FULL);
    assign empty_s = (count_r == {(DEPTH_LOG2 + 1){1'b0}});
    // Push admission uses the registered full flag only, so a same-cycle pop never frees a slot early.
    assign push_s  = wr & en & ~full_s;

    // Next-state decode: pop from IDLE, complete or abort from BUS.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (en && !empty_s) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_BUS;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (!en) begin
                    state_next_s = ST_IDLE;
                end else if (m_wb_ack_i) begin
                    done_s       = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_BUS;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= dat_i;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            wr_ptr_r   <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r   <= {DEPTH_LOG2{1'b0}};
            count_r    <= {(DEPTH_LOG2 + 1){1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + DEPTH_LOG2'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (DEPTH_LOG2 + 1)'(1);
                2'b01:   count_r <= count_r - (DEPTH_LOG2 + 1)'(1);
                default: count_r <= count_r;
            endcase
            if (wr && full_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Bus master state, registered strobes and progress counters; write data survives an abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cyc_r        <= 1'b0;
            stb_r        <= 1'b0;
            we_r         <= 1'b0;
            sel_r        <= 4'h0;
            offset_r     <= 9'd0;
            words_done_r <= 9'd0;
            dat_r        <= 32'd0;
        end else if (!en) begin
            state_r      <= ST_IDLE;
            cyc_r        <= 1'b0;
            stb_r        <= 1'b0;
            we_r         <= 1'b0;
            sel_r        <= 4'h0;
            offset_r     <= 9'd0;
            words_done_r <= 9'd0;
        end else begin
            state_r <= state_next_s;
            cyc_r   <= (state_next_s == ST_BUS);
            stb_r   <= (state_next_s == ST_BUS);
            we_r    <= (state_next_s == ST_BUS);
            sel_r   <= (state_next_s == ST_BUS) ? 4'hF : 4'h0;
            if (pop_s) begin
                dat_r <= mem_r[rd_ptr_r];
            end
            if (done_s) begin
                offset_r     <= offset_r + OFFSET_STEP;
                words_done_r <= words_done_r + 9'd1;
            end
        end
    end

    assign full       = full_s;
    assign empty      = empty_s;
    assign overflow   = overflow_r;
    assign words_done = words_done_r;
    // Offset wraps within one 512-byte block; the 32-bit sum discards its carry.
    assign m_wb_adr_o = adr + {23'd0, offset_r};
    assign m_wb_dat_o = dat_r;
    assign m_wb_sel_o = sel_r;
    assign m_wb_we_o  = we_r;
    assign m_wb_cyc_o = cyc_r;
    assign m_wb_stb_o = stb_r;

endmodule

// File: tb/tb_sd_fifo_rx_drainer.sv
// Bench for sd_fifo_rx_drainer: randomized pushes, a Wishbone slave model with
// configurable wait states, and expected writes derived from base + 4*k mod 512.
module tb_sd_fifo_rx_drainer;

    logic        clk = 1'b0;
    logic        rst, en, wr, ack;
    logic [31:0] adr, dat_i;
    logic        full, empty, overflow;
    logic [8:0]  words_done;
    logic [31:0] wb_adr, wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb;

    sd_fifo_rx_drainer #(.DEPTH_LOG2(3), .MEM_OFFSET(4)) dut (
        .clk(clk), .rst(rst), .en(en), .adr(adr), .wr(wr), .dat_i(dat_i),
        .full(full), .empty(empty), .overflow(overflow), .words_done(words_done),
        .m_wb_adr_o(wb_adr), .m_wb_dat_o(wb_dat), .m_wb_sel_o(wb_sel),
        .m_wb_we_o(wb_we), .m_wb_cyc_o(wb_cyc), .m_wb_stb_o(wb_stb),
        .m_wb_ack_i(ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_adr[$];
    logic [31:0] got_dat[$];
    int          stb_len[$];
    int          gaps[$];
    logic [31:0] exp_dat[$];
    bit          hold_ack   = 1'b0;
    bit          slave_rand = 1'b0;
    int          slave_wait = 0;
    bit          in_cyc     = 1'b0;
    int          wcnt = 0, cur_wait = 0, stb_cnt = 0, low_cnt = 0, bad_hold = 0;
    logic [31:0] fa, fd;

    // Wishbone slave and monitor: acks after cur_wait stall cycles, records completed writes.
    always @(negedge clk) begin
        if (wb_cyc && wb_stb) begin
            if (!in_cyc) begin
                in_cyc   = 1'b1;
                wcnt     = 0;
                stb_cnt  = 0;
                fa       = wb_adr;
                fd       = wb_dat;
                cur_wait = slave_rand ? int'($urandom_range(0, 3)) : slave_wait;
                gaps.push_back(low_cnt);
            end
            if (wb_adr !== fa || wb_dat !== fd || wb_we !== 1'b1 || wb_sel !== 4'hF)
                bad_hold++;
            stb_cnt++;
            if (!hold_ack && wcnt >= cur_wait) begin
                ack = 1'b1;
                got_adr.push_back(wb_adr);
                got_dat.push_back(wb_dat);
                stb_len.push_back(stb_cnt);
            end else begin
                ack = 1'b0;
                if (!hold_ack) wcnt++;
            end
            low_cnt = 0;
        end else begin
            ack    = 1'b0;
            in_cyc = 1'b0;
            low_cnt++;
        end
    end

    function automatic logic [31:0] exp_adr(input logic [31:0] base, input int k);
        logic [31:0] off;
        off = 32'((k * 4) % 512);
        return base + off;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        wr    = 1'b1;
        dat_i = w;
        tick();
        wr    = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget, input string tag);
        int k = 0;
        while (got_adr.size() < n && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (got_adr.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d writes, want %0d", tag, got_adr.size(), n);
        end
    endtask

    task automatic restart(input logic [31:0] base);
        en = 1'b0;
        tick();
        got_adr.delete(); got_dat.delete(); stb_len.delete(); gaps.delete(); exp_dat.delete();
        adr = base; hold_ack = 1'b0; slave_rand = 1'b0; slave_wait = 0; bad_hold = 0;
        en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; wr = 1'b0; ack = 1'b0; adr = 32'h1234; dat_i = 32'd0;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({empty, full, wb_cyc, wb_stb, wb_we, overflow} !== 6'b100000) begin
            errors++; $display("FAIL reset_flags: got %b want 100000", {empty, full, wb_cyc, wb_stb, wb_we, overflow});
        end
        checks++;
        if (wb_sel !== 4'h0 || wb_dat !== 32'd0 || words_done !== 9'd0) begin
            errors++; $display("FAIL reset_vals: sel %h dat %h wd %0d want 0 0 0", wb_sel, wb_dat, words_done);
        end
        checks++;
        if (wb_adr !== 32'h1234) begin
            errors++; $display("FAIL reset_adr: got %h want 00001234", wb_adr);
        end
    endtask

    task automatic test_basic();
        restart(32'h1000);
        exp_dat = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
        foreach (exp_dat[i]) push(exp_dat[i]);
        wait_writes(3, 50, "basic");
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i < got_adr.size() && (got_adr[i] !== exp_adr(32'h1000, i) || got_dat[i] !== exp_dat[i])) begin
                errors++; $display("FAIL basic_write%0d: got %h/%h want %h/%h", i, got_adr[i], got_dat[i], exp_adr(32'h1000, i), exp_dat[i]);
            end
        end
        checks++;
        if (gaps.size() != 3 || gaps[1] != 1 || gaps[2] != 1) begin
            errors++; $display("FAIL basic_gap: got %0d rises, gaps %p want 1-cycle gaps", gaps.size(), gaps);
        end
        checks++;
        if (words_done !== 9'd3 || empty !== 1'b1) begin
            errors++; $display("FAIL basic_done: wd %0d empty %b want 3 1", words_done, empty);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] a, b;
        restart(32'h1800);
        a = $urandom; b = $urandom;
        slave_wait = 4;
        push(a);
        checks++;
        if (wb_cyc !== 1'b0 || empty !== 1'b0) begin
            errors++; $display("FAIL latency_t0: cyc %b empty %b want 0 0", wb_cyc, empty);
        end
        push(b);
        slave_wait = 0;
        checks++;
        if (wb_stb !== 1'b1 || wb_dat !== a || empty !== 1'b0) begin
            errors++; $display("FAIL latency_t1: stb %b dat %h empty %b want 1 %h 0", wb_stb, wb_dat, empty, a);
        end
        tick(); tick();
        checks++;
        if (empty !== 1'b0 || wb_dat !== a) begin
            errors++; $display("FAIL stall_nopop: empty %b dat %h want 0 %h", empty, wb_dat, a);
        end
        wait_writes(2, 50, "stall");
        checks++;
        if (stb_len.size() < 2 || stb_len[0] != 5 || bad_hold != 0) begin
            errors++; $display("FAIL stall_hold: stb cycles %p, unstable %0d want 5, 0", stb_len, bad_hold);
        end
        checks++;
        if (got_dat.size() < 2 || got_dat[0] !== a || got_dat[1] !== b || got_adr[1] !== 32'h1804) begin
            errors++; $display("FAIL stall_order: got %p want %h %h", got_dat, a, b);
        end
    endtask

    task automatic test_overflow();
        restart(32'h3000);
        hold_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_dat.push_back($urandom);
            push(exp_dat[i]);
        end
        checks++;
        if (full !== 1'b1 || overflow !== 1'b1 || wb_dat !== exp_dat[0]) begin
            errors++; $display("FAIL overflow_flags: full %b ovf %b dat %h want 1 1 %h", full, overflow, wb_dat, exp_dat[0]);
        end
        hold_ack = 1'b0;
        wait_writes(9, 100, "overflow");
        repeat (6) tick();
        checks++;
        if (got_adr.size() != 9 || words_done !== 9'd9 || empty !== 1'b1) begin
            errors++; $display("FAIL overflow_count: writes %0d wd %0d empty %b want 9 9 1", got_adr.size(), words_done, empty);
        end
        for (int i = 0; i < 9 && i < got_adr.size(); i++) begin
            checks++;
            if (got_adr[i] !== exp_adr(32'h3000, i) || got_dat[i] !== exp_dat[i]) begin
                errors++; $display("FAIL overflow_write%0d: got %h/%h want %h/%h", i, got_adr[i], got_dat[i], exp_adr(32'h3000, i), exp_dat[i]);
            end
        end
    endtask

    task automatic test_stream_wrap();
        int bad = 0;
        restart(32'h2000);
        for (int i = 0; i < 130; i++) begin
            exp_dat.push_back($urandom);
            push(exp_dat[i]);
            tick();
        end
        wait_writes(130, 100, "stream");
        tick(); tick();
        checks++;
        if (got_adr.size() >= 129 && (got_adr[127] !== 32'h21FC || got_adr[128] !== 32'h2000)) begin
            errors++; $display("FAIL stream_wrap: w128 %h w129 %h want 000021fc 00002000", got_adr[127], got_adr[128]);
        end
        for (int i = 0; i < got_adr.size() && i < 130; i++)
            if (got_adr[i] !== exp_adr(32'h2000, i) || got_dat[i] !== exp_dat[i]) bad++;
        checks++;
        if (bad != 0 || words_done !== 9'd130) begin
            errors++; $display("FAIL stream_data: %0d bad writes, wd %0d want 0, 130", bad, words_done);
        end
    endtask

    task automatic test_random_bursts();
        int total = 0, bad = 0;
        restart(32'hFFFF_FFF0);
        slave_rand = 1'b1;
        for (int b = 0; b < 6; b++) begin
            int n = int'($urandom_range(1, 8));
            for (int i = 0; i < n; i++) begin
                exp_dat.push_back($urandom);
                push(exp_dat[total]);
                total++;
            end
            wait_writes(total, 200, "rand");
        end
        tick(); tick();
        for (int i = 0; i < got_adr.size() && i < total; i++)
            if (got_adr[i] !== exp_adr(32'hFFFF_FFF0, i) || got_dat[i] !== exp_dat[i]) bad++;
        checks++;
        if (bad != 0 || got_adr.size() != total || bad_hold != 0 || words_done !== 9'(total)) begin
            errors++; $display("FAIL rand_bursts: bad %0d writes %0d/%0d unstable %0d wd %0d", bad, got_adr.size(), total, bad_hold, words_done);
        end
    endtask

    task automatic test_en_abort();
        logic [31:0] w0, x;
        restart(32'h5000);
        hold_ack = 1'b1;
        w0 = $urandom;
        push(w0);
        for (int i = 1; i < 10; i++) push($urandom);
        en = 1'b0;
        tick();
        checks++;
        if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 || words_done !== 9'd0) begin
            errors++; $display("FAIL abort_clear: cyc %b stb %b empty %b full %b ovf %b wd %0d", wb_cyc, wb_stb, empty, full, overflow, words_done);
        end
        checks++;
        if (wb_dat !== w0 || wb_adr !== 32'h5000) begin
            errors++; $display("FAIL abort_hold: dat %h adr %h want %h 00005000", wb_dat, wb_adr, w0);
        end
        push(32'hDEAD_BEEF);
        checks++;
        if (empty !== 1'b1 || overflow !== 1'b0) begin
            errors++; $display("FAIL abort_ignore_wr: empty %b ovf %b want 1 0", empty, overflow);
        end
        got_adr.delete(); got_dat.delete();
        hold_ack = 1'b0; adr = 32'h6000; en = 1'b1;
        x = $urandom;
        push(x);
        wait_writes(1, 30, "abort");
        checks++;
        if (got_adr.size() > 0 && (got_adr[0] !== 32'h6000 || got_dat[0] !== x)) begin
            errors++; $display("FAIL abort_restart: got %h/%h want 00006000/%h", got_adr[0], got_dat[0], x);
        end
    endtask

    task automatic test_reset_mid_burst();
        restart(32'h4000);
        hold_ack = 1'b1;
        for (int i = 0; i < 4; i++) push($urandom);
        tick();
        checks++;
        if (wb_cyc !== 1'b1 || empty !== 1'b0) begin
            errors++; $display("FAIL midrst_setup: cyc %b empty %b want 1 0", wb_cyc, empty);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({wb_cyc, wb_stb, wb_we, empty, full, overflow} !== 6'b000100 || wb_sel !== 4'h0 || wb_dat !== 32'd0 ||
            words_done !== 9'd0 || wb_adr !== 32'h4000) begin
            errors++; $display("FAIL midrst_vals: flags %b sel %h dat %h wd %0d adr %h", {wb_cyc, wb_stb, wb_we, empty, full, overflow}, wb_sel, wb_dat, words_done, wb_adr);
        end
        rst = 1'b0; hold_ack = 1'b0;
        got_adr.delete(); got_dat.delete();
        repeat (10) tick();
        checks++;
        if (got_adr.size() != 0 || wb_cyc !== 1'b0) begin
            errors++; $display("FAIL midrst_nowrite: %0d writes, cyc %b want 0 0", got_adr.size(), wb_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_overflow();
        test_stream_wrap();
        test_random_bursts();
        test_en_abort();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
